// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for the 1-bit ALU slice: walks one bit per clock, LSB first,
// collecting the slice result into a shift register and producing result and flags.
module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic             o_slice_a,
  output logic             o_slice_b,
  output logic             o_slice_cin,
  output logic             o_slice_bnegate,
  output logic             o_slice_less,
  output logic [2:0]       o_slice_aluop,
  input  logic             i_slice_result,
  input  logic             i_slice_carry_out,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_XOR) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic op_negate(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic [2:0] slice_op(input logic [2:0] op);
    case (op)
      OP_AND:  return 3'b000;
      OP_OR:   return 3'b001;
      OP_XOR:  return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_shift;
  logic             r_cin_msb;
  logic             r_sum_msb;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_done;
  logic             r_error;

  logic             w_arith;
  logic             w_addsub;
  logic             w_slt_bit;
  logic [WIDTH-1:0] w_fin_result;

  assign w_arith      = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_SLT);
  assign w_addsub     = (r_op == OP_ADD) || (r_op == OP_SUB);
  // Signed less-than: sign of A-B corrected by the overflow of that subtraction.
  assign w_slt_bit    = r_sum_msb ^ r_cin_msb ^ r_carry;
  assign w_fin_result = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_slt_bit} : r_shift;

  always_comb begin
    o_slice_a       = 1'b0;
    o_slice_b       = 1'b0;
    o_slice_cin     = 1'b0;
    o_slice_bnegate = 1'b0;
    o_slice_less    = 1'b0;
    o_slice_aluop   = 3'b000;
    if (r_state == S_RUN) begin
      o_slice_a       = r_a[r_cnt];
      o_slice_b       = r_b[r_cnt];
      o_slice_cin     = r_carry;
      o_slice_bnegate = op_negate(r_op);
      o_slice_aluop   = slice_op(r_op);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 3'b000;
      r_shift     <= '0;
      r_cin_msb   <= 1'b0;
      r_sum_msb   <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A Start coinciding with the Done pulse is dropped, not deferred.
          if (i_start && !r_done) begin
            if (op_legal(i_op)) begin
              r_a     <= i_a;
              r_b     <= i_b;
              r_op    <= i_op;
              r_shift <= '0;
              r_carry <= op_negate(i_op);
              r_cnt   <= '0;
              r_state <= S_RUN;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_shift[r_cnt] <= i_slice_result;
            r_carry        <= i_slice_carry_out;
            if (r_cnt == LAST_BIT) begin
              r_cin_msb <= r_carry;
              r_sum_msb <= i_slice_result;
              r_state   <= S_FIN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          if (!i_abort) begin
            r_result    <= w_fin_result;
            r_carry_out <= w_arith & r_carry;
            r_overflow  <= w_addsub & (r_cin_msb ^ r_carry);
            r_zero      <= (w_fin_result == '0);
            r_done      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_result    = r_result;
  assign o_carry_out = r_carry_out;
  assign o_overflow  = r_overflow;
  assign o_zero      = r_zero;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: behavioural 1-bit slice, scoreboard of expected results.
module tb_alu_serial_ctrl;

  localparam int W = 8;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         s_a, s_b, s_cin, s_bneg, s_less;
  logic [2:0]   s_aluop;
  logic         s_res, s_cout;
  logic [W-1:0] result;
  logic         cout, ovf, zero, busy, done, err;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_a(a), .i_b(b), .i_op(op),
    .o_slice_a(s_a), .o_slice_b(s_b), .o_slice_cin(s_cin),
    .o_slice_bnegate(s_bneg), .o_slice_less(s_less), .o_slice_aluop(s_aluop),
    .i_slice_result(s_res), .i_slice_carry_out(s_cout),
    .o_result(result), .o_carry_out(cout), .o_overflow(ovf), .o_zero(zero),
    .o_busy(busy), .o_done(done), .o_error(err)
  );

  // Behavioural ALU slice
  always_comb begin
    logic bb;
    bb     = s_b ^ s_bneg;
    s_cout = (s_a & bb) | (s_a & s_cin) | (bb & s_cin);
    case (s_aluop)
      3'b000:  s_res = s_a & bb;
      3'b001:  s_res = s_a | bb;
      3'b010:  s_res = s_a ^ bb ^ s_cin;
      3'b100:  s_res = s_a ^ bb;
      default: s_res = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    s = '0;
    case (o)
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_ADD: begin
        s      = {1'b0, x} + {1'b0, y};
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      end
      OP_SUB: begin
        s      = {1'b0, x} + {1'b0, ~y} + 1;
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
      end
      default: begin
        s      = {1'b0, x} + {1'b0, ~y} + 1;
        e.res  = ($signed(x) < $signed(y)) ? 1 : 0;
        e.cout = s[W];
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  function automatic logic [2:0] exp_aluop(input logic [2:0] o);
    case (o)
      OP_AND:  return 3'b000;
      OP_OR:   return 3'b001;
      OP_XOR:  return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  // Full operation; intr_cyc>=0 pulses a foreign Start in that RUN cycle,
  // with_abort raises Abort together with the accepted Start.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int intr_cyc, input logic with_abort);
    exp_t e;
    logic neg;
    neg = (o == OP_SUB) || (o == OP_SLT);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; abort = with_abort;
    sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("busy_on", {31'd0, busy}, 32'd1);
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      chk($sformatf("run%0d_slice", c),
          {24'd0, busy, done, s_a, s_b, s_aluop, s_bneg},
          {24'd0, 1'b1, 1'b0, x[c], y[c], exp_aluop(o), neg});
      if (c == intr_cyc) begin
        start = 1'b1; op = OP_AND; a = ~x; b = ~y;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("fin_busy_done", {30'd0, busy, done}, 32'd2);
    @(negedge clk);
    chk("done_pulse", {30'd0, busy, done}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("result", {24'd0, result}, {24'd0, e.res});
      chk("flags", {29'd0, cout, ovf, zero}, {29'd0, e.cout, e.ovf, e.zero});
    end
    start = 1'b1; op = OP_ADD; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", {30'd0, busy, done}, 32'd0);
  endtask

  task automatic no_done_for(input string tag, input int ncyc);
    int seen;
    seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vals", {result, cout, ovf, zero, busy, done, err, s_a, s_b, s_cin, s_bneg, s_less, s_aluop},
        {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;

    run_op(OP_ADD, 8'h7F, 8'h01, -1, 1'b0);
    run_op(OP_SUB, 8'h05, 8'h07, -1, 1'b0);
    run_op(OP_SUB, 8'h07, 8'h07, -1, 1'b0);
    run_op(OP_SLT, 8'hFF, 8'h01, -1, 1'b0);
    run_op(OP_SLT, 8'h7F, 8'h80, -1, 1'b0);
    run_op(OP_SLT, 8'h80, 8'h7F, -1, 1'b0);
    run_op(OP_AND, 8'hC3, 8'h5A, -1, 1'b1);
    run_op(OP_OR,  8'hC3, 8'h5A,  3, 1'b0);
    run_op(OP_XOR, 8'hC3, 8'h5A, -1, 1'b0);

    // Illegal opcode: error pulse only
    @(negedge clk);
    op = 3'b011; a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", {30'd0, err, busy}, 32'd2);
    @(posedge clk); #1;
    chk("err_clear", {22'd0, err, busy, result}, {22'd0, 1'b0, 1'b0, 8'h99});

    // Abort in IDLE does nothing
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {23'd0, busy, result}, {23'd0, 1'b0, 8'h99});

    // Abort in RUN cycle 2
    @(negedge clk);
    op = OP_XOR; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle_next", {31'd0, busy}, 32'd0);
    no_done_for("abort_no_done", 12);
    chk("abort_keeps", {21'd0, result, cout, ovf, zero}, {21'd0, 8'h99, 3'b000});

    // Reset in RUN cycle 4
    @(negedge clk);
    op = OP_ADD; a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_midop", {result, cout, ovf, zero, busy, done, err, s_a, s_b, s_cin, s_bneg, s_less, s_aluop},
        {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    no_done_for("reset_no_done", 12);

    run_op(OP_ADD, 8'hFF, 8'h01, -1, 1'b0);
    run_op(OP_SUB, 8'h80, 8'h01, -1, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer for the team's 1-bit ALU slice: one slice is time-shared across a WIDTH-bit operation, one bit position per clock, LSB first.
- Latches operands and opcode on Start, drives slice inputs each cycle, and registers slice Result/CarryOut back into a shift register and carry flop.
- Produces the full-width result plus Zero, CarryOut and Overflow flags and a one-cycle Done pulse; sits between the CPU control unit and the slice.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- CNT_W, $clog2(WIDTH), bit-index counter width.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  request; accepted only when Busy=0
- Abort  input  1  cancel the running operation
- A  input  WIDTH  operand A, sampled at accepted Start
- B  input  WIDTH  operand B, sampled at accepted Start
- Op  input  3  000 AND, 001 OR, 010 ADD, 100 XOR, 110 SUB, 111 SLT (signed); others illegal
- SliceA  output  1  bit i of latched A
- SliceB  output  1  bit i of latched B
- SliceCIN  output  1  carry into slice
- SliceBNegate  output  1  slice B-invert select
- SliceLess  output  1  slice Less input; constant 0
- SliceALUOp  output  3  slice operation select
- SliceResult  input  1  slice result bit (combinational from slice inputs)
- SliceCarryOut  input  1  slice carry out
- Result  output  WIDTH  final result; holds until the next accepted Start
- CarryOut  output  1  carry out of the MSB (ADD/SUB/SLT), else 0
- Overflow  output  1  signed overflow (ADD/SUB), else 0
- Zero  output  1  Result == 0
- Busy  output  1  operation in progress
- Done  output  1  one-cycle completion pulse
- Error  output  1  one-cycle pulse on an illegal Op

Behaviour:
- Reset values: Result=0, CarryOut=0, Overflow=0, Zero=1, Busy=0, Done=0, Error=0, state=IDLE, bit counter=0, carry flop=0. All Slice* outputs are 0 in IDLE.
- FSM states: IDLE, RUN, FIN.
- IDLE, Start=1, legal Op:
  - Latch A, B and Op; clear the result shift register.
  - Carry flop loads 1 for SUB/SLT and 0 otherwise.
  - Go to RUN with counter=0 and Busy=1 from the next cycle.
- IDLE, Start=1, illegal Op: Error=1 for one cycle; stay in IDLE; Result and flags unchanged.
- RUN, slice drive (combinational from state and counter i):
  - SliceA=A[i], SliceB=B[i], SliceCIN=carry flop.
  - SliceALUOp: AND 000, OR 001, XOR 100, ADD/SUB/SLT 010.
  - SliceBNegate=1 for SUB/SLT only.
- RUN, each edge:
  - Shift SliceResult into the result register at bit i.
  - carry flop <= SliceCarryOut.
  - At i=WIDTH-1, also capture cin_msb (old carry flop) and the sum MSB, then go to FIN.
  - Otherwise i <= i+1.
- RUN lasts exactly WIDTH cycles.
- FIN, one cycle, updates outputs:
  - Result = shift register; for SLT, Result = {0..., sum_msb XOR ovf}.
  - CarryOut = carry flop (arithmetic ops only).
  - Overflow = cin_msb XOR carry flop (ADD/SUB only; 0 for SLT and logic ops).
  - Zero = (Result == 0).
  - Done=1, Busy=0 next cycle, return to IDLE.
- Latency: Start accepted at edge k -> Done high during the cycle after edge k+WIDTH+1; Busy high for WIDTH+1 cycles.
- Result and flags change only in FIN; they are stable between operations.
- Start while Busy=1 (RUN or FIN) is ignored; it is not queued.
- Start in the same cycle Done is high is ignored. The next Start is accepted in the following cycle.
- Abort in RUN or FIN: go to IDLE at the next edge. No Done; Result and flags keep their previous values. Abort in IDLE has no effect.
- Abort and Start in the same IDLE cycle: Start wins.
- Reset asserted mid-operation: immediate return to reset values; no Done.
- Arithmetic is modulo 2^WIDTH; SUB is A + ~B + 1.

Test Plan:
- WIDTH=8, ADD A=0x7F B=0x01 -> after 9 cycles Done pulse, Result=0x80, CarryOut=0, Overflow=1, Zero=0; SliceALUOp=010 and SliceBNegate=0 in all 8 RUN cycles.
- SUB A=0x05 B=0x07 -> Result=0xFE, CarryOut=0, Overflow=0; then SUB A=0x07 B=0x07 -> Result=0x00, Zero=1, CarryOut=1.
- SLT A=0xFF B=0x01 -> Result=0x01. SLT A=0x7F B=0x80 -> Result=0x00, Overflow=0. SLT A=0x80 B=0x7F -> Result=0x01.
- AND/OR/XOR with A=0xC3 B=0x5A -> 0x42 / 0xDB / 0x99; CarryOut=0, Overflow=0. Check SliceA/SliceB walk LSB to MSB.
- Start pulsed in RUN cycle 3 with different operands -> ignored, first result unchanged. Op=011 in IDLE -> Error pulse only, Busy stays 0.
- Reset asserted in RUN cycle 4 -> all outputs at reset values immediately, no Done. Abort in RUN cycle 2 -> IDLE next edge, previous Result retained.
